interboard_tx: RTL
==================

// Module: interboard_tx
// PURPOSE
//  Transmit side of the interboard link. Latches one game-control message from
//  the local controller, packs it into a 24-bit frame and sends it as four
//  6-bit words over Request/Ack/interboard_data with a four-phase handshake.
//  The top level owns the tri-states: it drives Request and interboard_data
//  from req_out/data_out when data_oe=1. The remote receive side answers on Ack.
// PARAMETERS
//  SETUP_CYC    4        clk cycles data_out is held stable before req_out rises
//  TIMEOUT_CYC  1048576  max clk cycles waiting on any single Ack edge
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous active-low reset (0 = reset)
//  ctrl_en        in   1   one-cycle start pulse; fields below sampled on it
//  ctrl_move_dir  in   1   move direction
//  ctrl_block_x   in   5   block x coordinate
//  ctrl_block_y   in   3   block y coordinate
//  ctrl_msg_type  in   4   message type
//  ctrl_card      in   6   card id
//  ctrl_sel_len   in   3   selection length
//  ack_in         in   1   raw Ack from remote board (asynchronous)
//  req_out        out  1   Request level to drive onto the link
//  data_out       out  6   current word to drive onto interboard_data
//  data_oe        out  1   1 = top drives Request/interboard_data, 0 = hi-Z
//  busy           out  1   1 from accept until return to IDLE
//  done           out  1   one-cycle pulse, frame fully acknowledged
//  timeout        out  1   one-cycle pulse, frame aborted on Ack timeout
// BEHAVIOUR
//  Reset: req_out=0, data_out=0, data_oe=0, busy=0, done=0, timeout=0,
//   state=IDLE, word index=0, counters=0, Ack synchronizer flops=0.
//  ack_in passes through a 2-FF synchronizer (ack_s). All decisions use ack_s.
//  Frame (MSB first): {msg_type[3:0], sel_len[2:0], move_dir, block_x[4:0],
//   block_y[2:0], card[5:0], 2'b10}. word0=frame[23:18] ... word3=frame[5:0].
//  The frame is latched on ctrl_en in IDLE. Later ctrl_* changes are ignored.
//  States:
//   IDLE   : data_oe=0, req_out=0. ctrl_en=1 -> latch, idx=0, cnt=0, SETUP.
//   SETUP  : data_oe=1, data_out=word[idx], req_out=0, cnt++.
//            cnt>=SETUP_CYC-1 and ack_s=0 -> REQ_HI, tcnt=0.
//   REQ_HI : req_out=1, wait ack_s=1 -> REQ_LO, tcnt=0.
//   REQ_LO : req_out=0, data held, wait ack_s=0 -> (idx==3 ? FINISH : idx++,
//            cnt=0, SETUP).
//   FINISH : done=1 for one cycle, data_oe=0 -> IDLE.
//   ABORT  : timeout=1 for one cycle, req_out=0, data_oe=0 -> IDLE.
//  Timeout: tcnt counts in REQ_HI and REQ_LO. tcnt reaching TIMEOUT_CYC-1
//   without the awaited ack_s level -> ABORT. Counter width is
//   $clog2(TIMEOUT_CYC)+1 and it does not wrap.
//  Latency: ctrl_en at cycle N -> data_oe=1 and word0 valid at N+1. req_out
//   rises at N+SETUP_CYC+1 if ack_s=0. One word costs at least SETUP_CYC+6
//   cycles with an immediate responder.
//  busy = (state != IDLE). ctrl_en while busy is dropped: no queueing, no error.
//  ctrl_en in the same cycle as FINISH/ABORT is dropped. It is accepted from
//   the following IDLE cycle.
//  If ack_s stays 1 in SETUP, the block waits there without a timeout.
//   Only a handshake edge wait is bounded.
//  rst asserted mid-frame: immediate return to reset values and the link is
//   released (data_oe=0). No done or timeout pulse is produced.
// TESTING
//  T1 fields type=5 sel=3 dir=1 x=0x0C y=2 card=0x2A, ideal responder ->
//     words 0x15,0x36,0x0A,0x2A in order, 4 req_out pulses, done=1 once, busy falls.
//  T2 second ctrl_en mid-frame with different fields -> ignored, words still
//     match T1, exactly one done.
//  T3 responder never raises Ack, TIMEOUT_CYC=64 -> timeout pulse 64 cycles after
//     req_out rises, req_out=0, data_oe=0, IDLE.
//  T4 rst=0 during word2 in REQ_HI -> next edge all outputs 0, no done, and a new
//     frame after release sends correctly.
//  T5 Ack held 1 before start -> stays in SETUP with req_out=0. Ack drops ->
//     req_out rises SETUP_CYC-aligned and frame completes.
//  T6 back-to-back: ctrl_en 1 cycle after done -> second frame accepted, data
//     correct, 2 done pulses total.

Source files
------------

// File: rtl/interboard_tx.sv
// Transmit side of the interboard link: latches one game-control message, packs it
// into a 24-bit frame and sends it as four 6-bit words with a four-phase Req/Ack handshake.
module interboard_tx #(
    parameter int SETUP_CYC   = 4,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_en,
    input  logic       ctrl_move_dir,
    input  logic [4:0] ctrl_block_x,
    input  logic [2:0] ctrl_block_y,
    input  logic [3:0] ctrl_msg_type,
    input  logic [5:0] ctrl_card,
    input  logic [2:0] ctrl_sel_len,
    input  logic       ack_in,
    output logic       req_out,
    output logic [5:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    localparam int CW = $clog2(SETUP_CYC) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_REQ_HI = 3'd2;
    localparam logic [2:0] ST_REQ_LO = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;
    localparam logic [2:0] ST_ABORT  = 3'd5;

    // Word 0 is the most significant slice of the frame.
    function automatic logic [5:0] word_sel(input logic [23:0] frame, input logic [1:0] idx);
        logic [5:0] w;
        case (idx)
            2'd0:    w = frame[23:18];
            2'd1:    w = frame[17:12];
            2'd2:    w = frame[11:6];
            2'd3:    w = frame[5:0];
            default: w = 6'd0;
        endcase
        return w;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [23:0]   frame_q, frame_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ack_meta_q, ack_sync_q;
    logic          ack_s;
    logic          req_out_q, req_out_d;
    logic [5:0]    data_out_q, data_out_d;
    logic          data_oe_q, data_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;

    assign ack_s = ack_sync_q;

    // Next-state, frame latch, word index and setup/timeout counters.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en) begin
                    frame_d = {ctrl_msg_type, ctrl_sel_len, ctrl_move_dir, ctrl_block_x,
                               ctrl_block_y, ctrl_card, 2'b10};
                    idx_d   = 2'd0;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // A stuck-high Ack parks us here unbounded; the counter saturates.
                if ((cnt_q >= SETUP_LAST) && !ack_s) begin
                    state_d = ST_REQ_HI;
                    tcnt_d  = {TW{1'b0}};
                end else if (cnt_q < SETUP_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    state_d = ST_REQ_LO;
                    tcnt_d  = {TW{1'b0}};
                end else if (tcnt_q >= TO_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_REQ_LO: begin
                if (!ack_s) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_SETUP;
                    end
                end else if (tcnt_q >= TO_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop.
    always_comb begin
        req_out_d  = (state_d == ST_REQ_HI);
        data_oe_d  = (state_d == ST_SETUP) || (state_d == ST_REQ_HI) || (state_d == ST_REQ_LO);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FINISH);
        timeout_d  = (state_d == ST_ABORT);
        if (data_oe_d) begin
            data_out_d = word_sel(frame_d, idx_d);
        end else begin
            data_out_d = 6'd0;
        end
    end

    // Two-flop synchronizer for the asynchronous Ack from the remote board.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= ack_in;
            ack_sync_q <= ack_meta_q;
        end
    end

    // Control state, frame and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            frame_q <= 24'd0;
            idx_q   <= 2'd0;
            cnt_q   <= {CW{1'b0}};
            tcnt_q  <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Registered link and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_out_q  <= 1'b0;
            data_out_q <= 6'd0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            req_out_q  <= req_out_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign req_out  = req_out_q;
    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule
